// File: rtl/mem_uart_tx.sv
// rtl/mem_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO
//
// Purpose: CPU native-bus peripheral that queues bytes in a small FIFO and
// serialises them on o_txd as 8N1 frames (start 0, 8 data bits LSB first,
// stop 1), with a programmable bit divider.
//
// Ports:
//   clk            clock, all state on rising edge
//   resetn         synchronous active-low reset
//   i_sel          address decode hit for this peripheral
//   i_mem_valid    bus request valid, held until o_mem_ready
//   i_mem_addr     word offset: 0 DATA, 1 STATUS, 2 DIV, 3 reserved
//   i_mem_wdata    write data
//   i_mem_wstrb    byte strobes, 0 means read
//   o_mem_rdata    read data, valid with o_mem_ready, else 0
//   o_mem_ready    registered single-cycle completion pulse
//   o_txd          registered serial output, idle high

module mem_uart_tx #(
  parameter int DIV_RESET  = 234,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_sel,
  input  logic        i_mem_valid,
  input  logic [1:0]  i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  input  logic [3:0]  i_mem_wstrb,
  output logic [31:0] o_mem_rdata,
  output logic        o_mem_ready,
  output logic        o_txd
);

  localparam int          AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] DIV_INIT   = 16'(DIV_RESET);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_cnt, w_cnt_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_txd, w_txd_nxt;
  logic [15:0]   r_div;
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          r_mem_ready;
  logic [31:0]   r_mem_rdata;

  logic          w_full, w_empty, w_tick, w_pop;
  logic          w_req, w_wr, w_push_req, w_push, w_done;
  logic [7:0]    w_head;
  logic [31:0]   w_status, w_rdata;
  logic          w_unused;

  assign w_full   = (r_count == FULL_COUNT);
  assign w_empty  = (r_count == '0);
  assign w_head   = r_fifo[r_rptr];
  assign w_tick   = (r_cnt == 16'd0);
  assign w_unused = ^i_mem_wdata[31:16];

  // Bus side: a request is taken only while no completion is pending.
  assign w_req      = i_sel && i_mem_valid && !r_mem_ready;
  assign w_wr       = |i_mem_wstrb;
  assign w_push_req = w_req && (i_mem_addr == 2'd0) && i_mem_wstrb[0];
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_done     = w_req && !(w_push_req && !w_push);

  assign w_status = {17'd0, 7'(r_count), 5'd0, (r_state != S_IDLE), w_empty, w_full};

  always_comb begin
    w_rdata = 32'd0;
    if (!w_wr) begin
      case (i_mem_addr)
        2'd1:    w_rdata = w_status;
        2'd2:    w_rdata = {16'd0, r_div};
        default: w_rdata = 32'd0;
      endcase
    end
  end

  // Transmit FSM. The counter reloads from r_div only at bit boundaries, so a
  // DIV write never stretches or shortens the bit currently on the wire.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_txd_nxt   = r_txd;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_txd_nxt = 1'b1;
        if (!w_empty) begin
          w_state_nxt = S_START;
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_cnt_nxt   = r_div;
          w_txd_nxt   = 1'b0;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_state_nxt = S_DATA;
          w_idx_nxt   = 3'd0;
          w_cnt_nxt   = r_div;
          w_txd_nxt   = r_shift[0];
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_cnt_nxt = r_div;
          if (r_idx == 3'd7) begin
            w_state_nxt = S_STOP;
            w_txd_nxt   = 1'b1;
          end else begin
            w_idx_nxt   = r_idx + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_txd_nxt   = r_shift[1];
          end
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (!w_empty) begin
            // Back-to-back frame: straight into START with no idle bit.
            w_state_nxt = S_START;
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_cnt_nxt   = r_div;
            w_txd_nxt   = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
            w_txd_nxt   = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_cnt       <= 16'd0;
      r_idx       <= 3'd0;
      r_shift     <= 8'd0;
      r_txd       <= 1'b1;
      r_div       <= DIV_INIT;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_mem_ready <= 1'b0;
      r_mem_rdata <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_txd       <= w_txd_nxt;
      r_mem_ready <= w_done;
      r_mem_rdata <= w_done ? w_rdata : 32'd0;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_req && w_wr && (i_mem_addr == 2'd2)) begin
        if (i_mem_wstrb[0]) r_div[7:0]  <= i_mem_wdata[7:0];
        if (i_mem_wstrb[1]) r_div[15:8] <= i_mem_wdata[15:8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && w_push) r_fifo[r_wptr] <= i_mem_wdata[7:0];
  end

  assign o_mem_ready = r_mem_ready;
  assign o_mem_rdata = r_mem_rdata;
  assign o_txd       = r_txd;

endmodule

// File: tb/tb_mem_uart_tx.sv
// tb/tb_mem_uart_tx.sv - self-checking bench for mem_uart_tx

module tb_mem_uart_tx;

  localparam int DEPTH   = 8;
  localparam int DIV_RST = 234;
  localparam int HMAX    = 100000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        sel = 1'b0;
  logic        mem_valid = 1'b0;
  logic [1:0]  mem_addr = 2'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [3:0]  mem_wstrb = 4'd0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        txd;

  always #5 clk = ~clk;

  mem_uart_tx #(.DIV_RESET(DIV_RST), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .i_sel       (sel),
    .i_mem_valid (mem_valid),
    .i_mem_addr  (mem_addr),
    .i_mem_wdata (mem_wdata),
    .i_mem_wstrb (mem_wstrb),
    .o_mem_rdata (mem_rdata),
    .o_mem_ready (mem_ready),
    .o_txd       (txd)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit txh [HMAX];

  // Reference model: pending bytes as a queue, the frame in flight as a
  // 10-symbol vector with a symbol position and cycles left in the symbol.
  logic [7:0]  q[$];
  bit          m_live = 0;
  bit          m_act = 0;
  logic [9:0]  m_frm = '1;
  int          m_pos = 0;
  int          m_rem = 0;
  logic [15:0] m_div = 16'(DIV_RST);
  bit          m_ready = 0;
  logic [31:0] m_rdata = 0;
  bit          m_txd = 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic m_start(input logic [15:0] d);
    logic [7:0] b;
    b = q.pop_front();
    m_frm = {1'b1, b, 1'b0};
    m_pos = 0;
    m_rem = int'(d);
    m_act = 1;
  endtask

  task automatic model_step();
    int          pre_cnt;
    bit          pre_busy;
    logic [15:0] pre_div;
    bit          req;
    bit          rdy;
    logic [31:0] rd;
    if (!resetn) begin
      q.delete();
      m_act = 0; m_pos = 0; m_rem = 0;
      m_div = 16'(DIV_RST);
      m_ready = 0; m_rdata = 0; m_txd = 1;
      m_live = 1;
      return;
    end
    pre_cnt  = q.size();
    pre_busy = m_act;
    pre_div  = m_div;
    req      = sel && mem_valid && !m_ready;
    if (!m_act) begin
      if (pre_cnt > 0) m_start(pre_div);
    end else if (m_rem > 0) begin
      m_rem--;
    end else if (m_pos < 9) begin
      m_pos++;
      m_rem = int'(pre_div);
    end else if (q.size() > 0) begin
      m_start(pre_div);
    end else begin
      m_act = 0;
    end
    m_txd = m_act ? m_frm[m_pos] : 1'b1;
    rdy = 0;
    rd  = 0;
    if (req) begin
      if (mem_addr == 2'd0 && mem_wstrb[0]) begin
        if (q.size() < DEPTH) begin
          q.push_back(mem_wdata[7:0]);
          rdy = 1;
        end
      end else begin
        rdy = 1;
        if (mem_wstrb == 4'd0) begin
          if (mem_addr == 2'd1) begin
            rd = 32'(pre_cnt) << 8;
            rd[0] = (pre_cnt == DEPTH);
            rd[1] = (pre_cnt == 0);
            rd[2] = pre_busy;
          end else if (mem_addr == 2'd2) begin
            rd = {16'd0, pre_div};
          end
        end else if (mem_addr == 2'd2) begin
          if (mem_wstrb[0]) m_div[7:0]  = mem_wdata[7:0];
          if (mem_wstrb[1]) m_div[15:8] = mem_wdata[15:8];
        end
      end
    end
    m_ready = rdy;
    m_rdata = rd;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        chk("txd", {31'd0, txd}, {31'd0, m_txd});
        chk("mem_ready", {31'd0, mem_ready}, {31'd0, m_ready});
        chk("mem_rdata", mem_rdata, m_rdata);
      end
      if (cyc < HMAX) txh[cyc] = txd;
      cyc++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd, output int lat);
    bit got;
    got = 0; lat = 0; rd = 0;
    sel = 1; mem_valid = 1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (mem_ready) begin
        got = 1;
        rd = mem_rdata;
      end
    end
    sel = 0; mem_valid = 0; mem_wstrb = 0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL bus_timeout cyc=%0d got=no_ready exp=ready addr=%0d", cyc, a);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    int lat;
    bus(a, d, s, rd, lat);
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    int lat;
    bus(a, 32'd0, 4'd0, rd, lat);
    chk(name, rd, exp);
  endtask

  function automatic logic [63:0] expand(input logic [19:0] syms, input int n, input int per);
    logic [63:0] r;
    r = '1;
    for (int k = 0; k < n * per; k++) r[k] = syms[k / per];
    return r;
  endfunction

  // Find the first low txd sample from 'from' and compare the recorded line
  // against an expected waveform, followed by an idle-high sample.
  task automatic wave_chk(input string name, input int from, input logic [63:0] pat, input int len);
    int f;
    f = -1;
    for (int i = from; i < cyc && i < HMAX; i++) begin
      if (txh[i] == 1'b0) begin
        f = i;
        break;
      end
    end
    if (f < 0 || f + len >= cyc) begin
      checks++; errors++;
      $display("FAIL %s_start cyc=%0d got=no_frame exp=frame", name, cyc);
    end else begin
      for (int k = 0; k < len; k++) chk(name, {31'd0, txh[f + k]}, {31'd0, pat[k]});
      chk({name, "_idle_after"}, {31'd0, txh[f + len]}, 32'd1);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20000 && (m_act || q.size() > 0); i++) @(negedge clk);
    if (m_act || q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout cyc=%0d got=busy exp=idle", cyc);
    end
    idle(3);
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    int          t0;
    int          r;
    bit          fell;

    resetn = 0;
    repeat (3) @(negedge clk);
    resetn = 1;

    bus(2'd1, 32'd0, 4'd0, rd, lat);
    chk("status_reset", rd, 32'h0000_0002);
    chk("status_latency", 32'(lat), 32'd1);
    chk("txd_idle", {31'd0, txd}, 32'd1);
    rd_chk("div_reset", 2'd2, 32'd234);

    wr(2'd2, 32'h0000_1234, 4'hF);
    wr(2'd2, 32'h0000_0010, 4'b0001);
    rd_chk("div_low_byte", 2'd2, 32'h0000_1210);
    wr(2'd3, 32'hFFFF_FFFF, 4'hF);
    rd_chk("rsvd_read", 2'd3, 32'd0);
    rd_chk("div_after_rsvd", 2'd2, 32'h0000_1210);
    rd_chk("data_read", 2'd0, 32'd0);

    wr(2'd2, 32'd3, 4'b0011);
    t0 = cyc - 2;
    wr(2'd0, 32'h55, 4'b0001);
    idle(50);
    wave_chk("frame_55", t0, expand(20'h002AA, 10, 4), 40);
    rd_chk("status_after_frame", 2'd1, 32'h0000_0002);

    wr(2'd2, 32'd0, 4'b0011);
    t0 = cyc - 2;
    wr(2'd0, 32'h00, 4'b0001);
    wr(2'd0, 32'h00, 4'b0001);
    idle(30);
    wave_chk("back_to_back", t0, expand(20'h80200, 20, 1), 20);

    wr(2'd2, 32'd3, 4'b0011);
    for (int i = 0; i < 9; i++) wr(2'd0, 32'hA0 + 32'(i), 4'b0001);
    rd_chk("status_full", 2'd1, 32'h0000_0805);
    bus(2'd0, 32'hB9, 4'b0001, rd, lat);
    chk("full_write_stalls", 32'(lat > 2), 32'd1);
    drain();

    wr(2'd0, 32'hA5, 4'b0001);
    wr(2'd0, 32'h3C, 4'b0001);
    fell = 0;
    for (int i = 0; i < 100 && !fell; i++) begin
      @(negedge clk);
      if (txd == 1'b0) fell = 1;
    end
    chk("frame_began", {31'd0, fell}, 32'd1);
    idle(10);
    sel = 1; mem_valid = 1; mem_addr = 2'd1; mem_wstrb = 4'd0;
    resetn = 0;
    @(negedge clk);
    chk("reset_txd", {31'd0, txd}, 32'd1);
    chk("reset_ready", {31'd0, mem_ready}, 32'd0);
    @(negedge clk);
    resetn = 1; sel = 0; mem_valid = 0;
    idle(2);
    rd_chk("status_after_reset", 2'd1, 32'h0000_0002);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      chk("no_residual_frame", {31'd0, txd}, 32'd1);
    end
    rd_chk("div_after_reset", 2'd2, 32'd234);

    wr(2'd2, 32'($urandom_range(0, 3)), 4'b0011);
    for (int it = 0; it < 250; it++) begin
      r = $urandom_range(0, 99);
      if (r < 50) begin
        wr(2'd0, $urandom, 4'($urandom_range(1, 15)));
      end else if (r < 60) begin
        wr(2'd1, $urandom, 4'd0);
      end else if (r < 67) begin
        wr(2'd2, 32'd0, 4'd0);
      end else if (r < 72) begin
        wr(2'd3, $urandom, 4'($urandom_range(0, 15)));
      end else if (r < 78) begin
        case ($urandom_range(0, 3))
          0: wr(2'd2, 32'($urandom_range(0, 3)), 4'b0011);
          1: wr(2'd2, {$urandom, 8'($urandom_range(0, 3))} & 32'hFFFF_FF03, 4'b0001);
          2: wr(2'd2, 32'd0, 4'b0010);
          default: wr(2'd2, $urandom, 4'b1100);
        endcase
      end else if (r < 82) begin
        wr(2'd1, $urandom, 4'hF);
      end else if (r < 94) begin
        sel = 0; mem_valid = 1'($urandom_range(0, 1));
        mem_addr = 2'($urandom_range(0, 3)); mem_wdata = $urandom; mem_wstrb = 4'hF;
        idle($urandom_range(1, 30));
        mem_valid = 0; mem_wstrb = 0;
      end else if (r < 97) begin
        resetn = 0;
        idle($urandom_range(1, 2));
        resetn = 1;
        wr(2'd2, 32'($urandom_range(0, 3)), 4'b0011);
      end else begin
        idle($urandom_range(1, 5));
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
